// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between fetch and data ports, data first with a fetch starvation guard
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t state, state_nx;
  logic owner_d;
  logic [CW-1:0] starve_cnt;
  logic grant_d, grant_if;
  // data wins unless fetch has already waited through STARVE_LIMIT data grants
  always_comb begin
    grant_d  = d_req && !(if_req && starve_cnt == LIMIT);
    grant_if = if_req && !grant_d;
    state_nx = state == IDLE ? ((if_req || d_req) ? BUSY : IDLE) :
               state == BUSY ? (mem_ready ? ACK : BUSY) : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // memory request, ack pulses, read data capture and starvation counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (state == IDLE) begin
        starve_cnt <= (grant_d && if_req) ? ((starve_cnt == LIMIT) ? LIMIT : starve_cnt + CW'(1)) : '0;
        if (grant_d || grant_if) begin
          owner_d    <= grant_d;
          mem_req    <= 1'b1;
          mem_we     <= grant_d && d_we;
          mem_addr   <= grant_d ? d_addr : if_addr;
          mem_wdata  <= grant_d ? d_wdata : '0;
          mem_funct3 <= grant_d ? d_funct3 : 3'b010;
        end
      end else if (state == BUSY && mem_ready) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (owner_d) begin
          d_ack <= 1'b1;
          if (!mem_we) d_rdata <= mem_rdata;
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a memory model and arbitration scoreboard
module tb_mem_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0] d_funct3 = '0;
  logic if_ack, d_ack, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0] mem_funct3;
  logic [31:0] mem_rdata = '0;
  logic mem_ready = 1'b0;
  int n_cmp = 0, n_err = 0;
  logic [31:0] mem [logic [31:0]];
  int lat = 0, lat_cur = 0, wcnt = 0;
  bit lat_rand = 1'b0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {a[15:0], ~a[15:0]};
  endfunction

  // memory model: answers after lat wait cycles, junk on the bus while idle
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wcnt == 0) lat_cur = lat_rand ? int'($urandom_range(0, 3)) : lat;
      if (wcnt >= lat_cur) begin
        mem_ready = 1'b1;
        mem_rdata = rd(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if ({mem_req, mem_we, if_ack, d_ack, mem_funct3, mem_addr, mem_wdata, if_rdata, d_rdata} !== 135'h0) begin n_err++; $display("FAIL reset_state got %h want 0", {mem_req, mem_we, if_ack, d_ack, mem_funct3, mem_addr, mem_wdata, if_rdata, d_rdata}); end
    rst = 1'b0;
  endtask

  task automatic test_lone_fetch();
    lat = 0;
    mem[32'h100] = 32'h00500093;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, if_ack, d_ack} !== {1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2'b00}) begin n_err++; $display("FAIL lone_issue got %h want %h", {mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, if_ack, d_ack}, {1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2'b00}); end
    tick();
    n_cmp++; if ({if_ack, d_ack, mem_req, if_rdata} !== {3'b100, 32'h00500093}) begin n_err++; $display("FAIL lone_ack got %h want %h", {if_ack, d_ack, mem_req, if_rdata}, {3'b100, 32'h00500093}); end
    if_req = 1'b0;
    tick();
    n_cmp++; if ({if_ack, d_ack, mem_req} !== 3'b000) begin n_err++; $display("FAIL lone_idle got %b want 000", {if_ack, d_ack, mem_req}); end
  endtask

  task automatic test_simultaneous();
    lat = 0;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_funct3, mem_addr, mem_wdata} !== {1'b1, 1'b1, 3'b010, 32'h2000, 32'hDEADBEEF}) begin n_err++; $display("FAIL simul_store_issue got %h want %h", {mem_req, mem_we, mem_funct3, mem_addr, mem_wdata}, {1'b1, 1'b1, 3'b010, 32'h2000, 32'hDEADBEEF}); end
    tick();
    n_cmp++; if ({if_ack, d_ack, d_rdata} !== {2'b01, 32'h0}) begin n_err++; $display("FAIL simul_store_ack got %h want %h", {if_ack, d_ack, d_rdata}, {2'b01, 32'h0}); end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    n_cmp++; if ({mem_req, if_ack, d_ack} !== 3'b000) begin n_err++; $display("FAIL simul_idle got %b want 000", {mem_req, if_ack, d_ack}); end
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_funct3, mem_addr, mem_wdata} !== {1'b1, 1'b0, 3'b010, 32'h104, 32'h0}) begin n_err++; $display("FAIL simul_fetch_issue got %h want %h", {mem_req, mem_we, mem_funct3, mem_addr, mem_wdata}, {1'b1, 1'b0, 3'b010, 32'h104, 32'h0}); end
    tick();
    n_cmp++; if ({if_ack, d_ack, if_rdata, d_rdata} !== {2'b10, rd(32'h104), 32'h0}) begin n_err++; $display("FAIL simul_fetch_ack got %h want %h", {if_ack, d_ack, if_rdata, d_rdata}, {2'b10, rd(32'h104), 32'h0}); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    lat = 3;
    mem[32'h2004] = 32'h12345678;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004; d_wdata = 32'h0; d_funct3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({mem_req, mem_addr, d_ack} !== {1'b1, 32'h2004, 1'b0}) begin n_err++; $display("FAIL wait_hold cycle %0d got %h want %h", i, {mem_req, mem_addr, d_ack}, {1'b1, 32'h2004, 1'b0}); end
    end
    tick();
    n_cmp++; if ({d_ack, if_ack, mem_req, d_rdata} !== {3'b100, 32'h12345678}) begin n_err++; $display("FAIL wait_ack got %h want %h", {d_ack, if_ack, mem_req, d_rdata}, {3'b100, 32'h12345678}); end
    d_req = 1'b0;
    tick();
    n_cmp++; if (d_ack !== 1'b0) begin n_err++; $display("FAIL wait_single_pulse got %b want 0", d_ack); end
    lat = 0;
  endtask

  task automatic test_starvation();
    string got = "";
    int acks = 0, cyc = 0;
    bit prev = 1'b0;
    lat = 0;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'h0; d_funct3 = 3'b010;
    while (acks < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (mem_req && !prev) begin
        if (mem_addr >= 32'h3000) got = {got, "D"};
        else got = {got, "F"};
      end
      prev = mem_req;
      if (d_ack) begin d_addr = d_addr + 32'd4; acks++; end
      if (if_ack) begin if_addr = if_addr + 32'd4; acks++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    n_cmp++; if (got != "DDDDFDDDDF") begin n_err++; $display("FAIL starve_order got %s want DDDDFDDDDF", got); end
    tick();
  endtask

  task automatic test_reset_mid();
    lat = 10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008;
    tick();
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy got %b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({mem_req, if_ack, d_ack} !== 3'b000) begin n_err++; $display("FAIL rst_mid_async got %b want 000", {mem_req, if_ack, d_ack}); end
    d_req = 1'b0;
    tick();
    n_cmp++; if ({mem_req, if_ack, d_ack, if_rdata, d_rdata} !== 67'h0) begin n_err++; $display("FAIL rst_mid_held got %h want 0", {mem_req, if_ack, d_ack, if_rdata, d_rdata}); end
    rst = 1'b0; lat = 0;
    mem[32'h0] = 32'hCAFE0013;
    if_req = 1'b1; if_addr = 32'h0;
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, d_ack} !== {1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0}) begin n_err++; $display("FAIL rst_mid_refetch_issue got %h want %h", {mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, d_ack}, {1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0}); end
    tick();
    n_cmp++; if ({if_ack, d_ack, if_rdata} !== {2'b10, 32'hCAFE0013}) begin n_err++; $display("FAIL rst_mid_refetch_ack got %h want %h", {if_ack, d_ack, if_rdata}, {2'b10, 32'hCAFE0013}); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_held_request();
    lat = 0;
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin n_err++; $display("FAIL held_first_issue got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h300}); end
    tick();
    n_cmp++; if (if_ack !== 1'b1) begin n_err++; $display("FAIL held_first_ack got %b want 1", if_ack); end
    tick();
    n_cmp++; if ({mem_req, if_ack} !== 2'b00) begin n_err++; $display("FAIL held_gap got %b want 00", {mem_req, if_ack}); end
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin n_err++; $display("FAIL held_reissue got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h300}); end
    tick();
    n_cmp++; if (if_ack !== 1'b1) begin n_err++; $display("FAIL held_second_ack got %b want 1", if_ack); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_drop_early();
    int pulses = 0;
    lat = 2;
    if_req = 1'b1; if_addr = 32'h400;
    tick();
    if_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if_ack) begin
        pulses++;
        n_cmp++; if (if_rdata !== rd(32'h400)) begin n_err++; $display("FAIL drop_rdata got %h want %h", if_rdata, rd(32'h400)); end
      end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL drop_ack_count got %0d want 1", pulses); end
    lat = 0;
  endtask

  task automatic test_random();
    int cnt = 0, done = 0, cyc = 0;
    bit own_d = 1'b0, prev_req = 1'b0, fin;
    logic [31:0] val = '0, exp_d = '0;
    logic [67:0] exp_iss;
    lat_rand = 1'b1;
    while ((done < 40 || if_req || d_req) && cyc < 4000) begin
      tick();
      cyc++;
      if (mem_req && !prev_req) begin
        own_d = d_req && !(if_req && cnt == LIM);
        exp_iss = own_d ? {d_we, d_funct3, d_addr, d_wdata} : {1'b0, 3'b010, if_addr, 32'h0};
        n_cmp++; if ({mem_we, mem_funct3, mem_addr, mem_wdata} !== exp_iss) begin n_err++; $display("FAIL rand_issue cyc %0d got %h want %h", cyc, {mem_we, mem_funct3, mem_addr, mem_wdata}, exp_iss); end
        val = rd(own_d ? d_addr : if_addr);
        cnt = (own_d && if_req) ? ((cnt == LIM) ? LIM : cnt + 1) : 0;
      end
      fin = prev_req && !mem_req;
      n_cmp++; if ({if_ack, d_ack} !== (fin ? (own_d ? 2'b01 : 2'b10) : 2'b00)) begin n_err++; $display("FAIL rand_ack cyc %0d got %b want %b", cyc, {if_ack, d_ack}, fin ? (own_d ? 2'b01 : 2'b10) : 2'b00); end
      if (fin) begin
        if (own_d && !d_we) exp_d = val;
        n_cmp++; if (own_d ? (d_rdata !== exp_d) : (if_rdata !== val)) begin n_err++; $display("FAIL rand_rdata cyc %0d got %h want %h", cyc, own_d ? d_rdata : if_rdata, own_d ? exp_d : val); end
        if (own_d) d_req = 1'b0;
        else if_req = 1'b0;
        done++;
      end
      prev_req = mem_req;
      if (done < 40 && !if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
      end
      if (done < 40 && !d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'h8000 + 32'($urandom_range(0, 15)) * 32'd4;
        d_wdata = $urandom;
        d_funct3 = 3'($urandom_range(0, 7));
      end
    end
    n_cmp++; if (cyc >= 4000) begin n_err++; $display("FAIL rand_timeout got %0d acks want 40 within 4000 cycles", done); end
    lat_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_wait_states();
    test_starvation();
    test_reset_mid();
    test_held_request();
    test_drop_early();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500us");
    $fatal(1);
  end
endmodule
